key_event_queue: RTL
====================

Name: key_event_queue

Overview:
- Parametrised successor to the single-register keycode recognizer in the game system.
- Decodes the raw PS/2 scan-code byte stream (key_en/key_data) into complete key events and buffers them in a FIFO with a valid/ready handshake, so the processor FSM never drops keys while busy drawing.
- Also maintains a held-key bitmap for the four arrow keys and space, and optionally suppresses typematic repeats.
- Sits between the PS/2 byte receiver and the processor.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- SUPPRESS_REPEAT, 1, 1 = a make event for a key already held is not enqueued.
- PAUSE_SKIP, 7, bytes discarded after an E1 prefix (Pause key sequence).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_en  in  1  one-cycle strobe: key_data valid.
- key_data  in  8  raw scan-code byte.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head when ev_valid=1.
- ev_keycode  out  8  head keycode.
- ev_make  out  1  head is make (1) or break (0).
- ev_ext  out  1  head had E0 prefix.
- held  out  5  {space, right, left, down, up} currently pressed.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky: an event was lost.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset: ev_valid=0, ev_keycode=0, ev_make=0, ev_ext=0, held=0, count=0, overflow=0, decoder in IDLE, skip counter 0. Reset mid-sequence discards partial prefixes.
- Decoder FSM, advanced only on key_en=1:
  - IDLE: E0→EXT; F0→BRK; E1→SKIP (load PAUSE_SKIP); other → emit make, ext=0.
  - EXT: F0→EXT_BRK; E0→EXT; other → emit make, ext=1, →IDLE.
  - BRK: other → emit break, ext=0, →IDLE.
  - EXT_BRK: other → emit break, ext=1, →IDLE.
  - SKIP: decrement on each byte; →IDLE when the counter reaches 0 (the PAUSE_SKIP-th byte is consumed). Nothing is emitted.
  - An F0 or E0 received in BRK/EXT_BRK is treated as a keycode byte, as are E1 and F0 received in EXT_BRK.
- Tracked keys (exact match):
  - up = E0 75, down = E0 72, left = E0 6B, right = E0 74, space = 29 (ext=0).
  - held bit set on make and cleared on break, updated on the same edge the event is emitted.
- Repeat suppression: if SUPPRESS_REPEAT=1 and a make matches a tracked key whose held bit is already 1, no FIFO write occurs. Untracked keys are never suppressed.
- Latency:
  - Terminal byte with key_en in cycle N → FIFO write at end of N → ev_valid=1 in N+1 if the FIFO was empty.
  - No combinational bypass.
- FIFO:
  - Head outputs are registered/memory-read; they hold stable while ev_valid=1 and ev_ready=0.
  - Pop occurs when ev_valid & ev_ready.
- Boundaries:
  - Push when full and no pop: event dropped, overflow←1, contents unchanged.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when count=1: count stays 1, new head next cycle.
  - Pointers wrap modulo DEPTH.
  - clr_overflow and an overflow event in the same cycle: overflow stays 1 (set wins).
  - ev_ready while empty: ignored.
- held is independent of FIFO state: it updates even if the event is dropped or suppressed.

Decomposition:
- Shared package kbd_pkg:
  - scan-code constants SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, and the five tracked codes;
  - decoder state enum (IDLE, EXT, BRK, EXT_BRK, SKIP);
  - event struct {keycode[7:0], make, ext}.
- One natural sub-module: sync_fifo (parameters WIDTH=10, DEPTH), with push/pop/full/empty/count.
- Decoder, held bitmap and overflow logic stay in key_event_queue.

Test Plan:
- Bytes 1C, then F0 1C; ev_ready=1 → events {1C,make,ext0} then {1C,break,ext0}; held=0 throughout.
- Bytes E0 75, then E0 F0 75 → event {75,1,1} with held[0]=1 in the same cycle it is written; then {75,0,1} with held[0]=0.
- SUPPRESS_REPEAT=1; E0 6B sent 3 times, then E0 F0 6B → only 2 events (make, break); count peaks at 2 with ev_ready=0.
- DEPTH=4, ev_ready=0, 5 makes (15,1D,24,2D,2C) → count=4, overflow=1, the first 4 drain in order. Then clr_overflow → overflow=0.
- Full FIFO with ev_ready=1 and a new make in the same cycle → count stays 4, overflow stays 0, new key appears last.
- E1 14 77 E1 F0 14 F0 77 then 1C → only {1C,1,0} emitted. Separately, reset asserted after E0 F0, then 74 → {74,make,ext0}.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scan-code constants, decoder state type and event record for the
// keyboard event queue.
//   SC_*        : PS/2 set-2 prefix bytes and the five tracked keycodes
//   dec_state_t : byte-stream decoder states
//   key_event_t : one decoded key event {keycode, make, ext}
//   track_mask  : one-hot position of a tracked key in the held bitmap
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } dec_state_t;

  typedef struct packed {
    logic [7:0] keycode;
    logic       make;
    logic       ext;
  } key_event_t;

  // Bit order matches held: {space, right, left, down, up}.
  // Arrows only count with the E0 prefix, space only without it.
  function automatic logic [4:0] track_mask(input logic [7:0] code, input logic ext);
    logic [4:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    m[0] = 1'b1;
        SC_DOWN:  m[1] = 1'b1;
        SC_LEFT:  m[2] = 1'b1;
        SC_RIGHT: m[3] = 1'b1;
        default:  m = '0;
      endcase
    end else if (code == SC_SPACE) begin
      m[4] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Key event stream handshake between the queue (master) and the processor
// (slave).
//   ev_valid   : head of queue holds an event
//   ev_ready   : consumer accepts the head this cycle
//   ev_keycode : head keycode
//   ev_make    : head is a make (1) or break (0)
//   ev_ext     : head carried the E0 prefix
interface key_event_queue_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_keycode;
  logic       ev_make;
  logic       ev_ext;

  modport master (
    output ev_valid,
    output ev_keycode,
    output ev_make,
    output ev_ext,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_keycode,
    input  ev_make,
    input  ev_ext,
    output ev_ready
  );
endinterface

// File: rtl/key_event_queue_sync_fifo.sv
// Synchronous FIFO with registered storage and a memory-read head.
//   clk, reset : clock, synchronous active-high reset
//   push       : write wr_data; accepted when not full, or when full and
//                popping in the same cycle
//   pop        : remove head; ignored when empty
//   rd_data    : current head entry
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i[AW-1:0]] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// PS/2 scan-code decoder feeding a key event FIFO.
//   clk, reset   : clock, synchronous active-high reset
//   key_en       : one-cycle strobe, key_data valid
//   key_data     : raw scan-code byte
//   ev           : event stream (valid/ready, keycode, make, ext)
//   held         : {space, right, left, down, up} currently pressed
//   count        : FIFO occupancy
//   overflow     : sticky, an event was lost to a full FIFO
//   clr_overflow : clears overflow (an overflow in the same cycle wins)
module key_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1,
  parameter int PAUSE_SKIP      = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_en,
  input  logic [7:0]             key_data,
  key_event_queue_if.master      ev,
  output logic [4:0]             held,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int SKW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  dec_state_t     state;
  dec_state_t     state_nxt;
  logic [SKW-1:0] skip_cnt;
  logic [SKW-1:0] skip_nxt;

  logic       emit;
  logic       emit_make;
  logic       emit_ext;
  logic [4:0] mask;
  logic       suppress;
  logic       push;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  key_event_t wr_ev;
  key_event_t head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    emit      = 1'b0;
    emit_make = 1'b0;
    emit_ext  = 1'b0;
    if (key_en) begin
      case (state)
        IDLE: begin
          if (key_data == SC_EXT) begin
            state_nxt = EXT;
          end else if (key_data == SC_BRK) begin
            state_nxt = BRK;
          end else if (key_data == SC_PAUSE) begin
            if (PAUSE_SKIP != 0) begin
              state_nxt = SKIP;
              skip_nxt  = SKW'(PAUSE_SKIP);
            end
          end else begin
            emit      = 1'b1;
            emit_make = 1'b1;
          end
        end
        EXT: begin
          if (key_data == SC_BRK) begin
            state_nxt = EXT_BRK;
          end else if (key_data != SC_EXT) begin
            emit      = 1'b1;
            emit_make = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = IDLE;
          end
        end
        // Any byte after a break prefix is the keycode, prefixes included.
        BRK: begin
          emit      = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          emit      = 1'b1;
          emit_ext  = 1'b1;
          state_nxt = IDLE;
        end
        SKIP: begin
          skip_nxt = skip_cnt - 1'b1;
          if (skip_cnt == SKW'(1)) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mask     = track_mask(key_data, emit_ext);
  assign suppress = SUPPRESS_REPEAT && emit_make && ((mask & held) != '0);
  assign push     = emit && !suppress;
  assign pop      = ev.ev_valid && ev.ev_ready;
  assign drop     = push && fifo_full && !pop;

  assign wr_ev.keycode = key_data;
  assign wr_ev.make    = emit_make;
  assign wr_ev.ext     = emit_ext;

  // held follows every decoded event, even ones suppressed or dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= '0;
      overflow <= 1'b0;
    end else begin
      if (emit) begin
        held <= emit_make ? (held | mask) : (held & ~mask);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_ev),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign ev.ev_valid   = !fifo_empty;
  assign ev.ev_keycode = head.keycode;
  assign ev.ev_make    = head.make;
  assign ev.ev_ext     = head.ext;

endmodule
